// File: rtl/dvp_tx.sv
// dvp_tx: parallel camera-port (DVP) transmitter.
// Generates vsync/href frame timing and serialises RGB565 pixels high byte
// first, one byte per clock, pulling pixels through a pix_req handshake.
// Optional feature macro: DVP_TX_TEST_PATTERN_EN replaces the handshake with
// an internal 8-bar colour pattern.
module dvp_tx #(
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 480,
    parameter int H_BLANK   = 16,
    parameter int VSYNC_LEN = 4,
    parameter int V_BACK    = 8,
    parameter int V_FRONT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        pix_req,
    input  logic [15:0] pix_data,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int CW = $clog2(LINE_LEN + V_ACTIVE + VSYNC_LEN + V_BACK + V_FRONT + 1);

    localparam logic [CW-1:0] H_LAST      = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] H_REQ_FIRST = CW'(LINE_LEN - 2);
    localparam logic [CW-1:0] H_ACT_END   = CW'(2 * H_ACTIVE);
    localparam logic [CW-1:0] H_REQ_LIM   = CW'(2 * H_ACTIVE - 2);
    localparam logic [CW-1:0] VS_LAST     = CW'(VSYNC_LEN - 1);
    localparam logic [CW-1:0] VB_LAST     = CW'(V_BACK - 1);
    localparam logic [CW-1:0] VA_LAST     = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] VF_LAST     = CW'(V_FRONT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   h, v, h_nx, v_nx, v_last;
    logic [7:0]      low_byte;
    logic [15:0]     pixel;
    logic            href_nx, hi_slot, req_nx;
    logic [7:0]      data_nx;

`ifdef DVP_TX_TEST_PATTERN_EN
    // Bars narrower than one pixel make no sense, so small lines use width 1.
    localparam int BAR_W_INT = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
    localparam logic [CW-1:0] BAR_W = CW'(BAR_W_INT);

    logic [CW-1:0] pix_idx, bar;

    // Colour of the pixel about to be shown; leftover pixels extend the last bar.
    always_comb begin
        pixel   = 16'h0000;
        pix_idx = h_nx >> 1;
        bar     = pix_idx / BAR_W;
        if (bar > CW'(7)) begin
            bar = CW'(7);
        end
        case (bar[2:0])
            3'd0: pixel = 16'hFFFF;
            3'd1: pixel = 16'hFFE0;
            3'd2: pixel = 16'h07FF;
            3'd3: pixel = 16'h07E0;
            3'd4: pixel = 16'hF81F;
            3'd5: pixel = 16'hF800;
            3'd6: pixel = 16'h001F;
            default: pixel = 16'h0000;
        endcase
    end
`else
    // External pixels arrive on pix_data the cycle after each request.
    always_comb begin
        pixel = pix_data;
    end
`endif

    // Number of the last line belonging to the current state.
    always_comb begin
        v_last = '0;
        case (state)
            ST_VSYNC:  v_last = VS_LAST;
            ST_VBACK:  v_last = VB_LAST;
            ST_ACTIVE: v_last = VA_LAST;
            ST_VFRONT: v_last = VF_LAST;
            default:   v_last = '0;
        endcase
    end

    // Next frame position: enable only matters in IDLE and at the end of VFRONT.
    always_comb begin
        state_nx = state;
        h_nx     = h;
        v_nx     = v;
        case (state)
            ST_IDLE: begin
                h_nx = '0;
                v_nx = '0;
                if (enable) begin
                    state_nx = ST_VSYNC;
                end
            end
            default: begin
                if (h == H_LAST) begin
                    h_nx = '0;
                    if (v == v_last) begin
                        v_nx = '0;
                        case (state)
                            ST_VSYNC:  state_nx = ST_VBACK;
                            ST_VBACK:  state_nx = ST_ACTIVE;
                            ST_ACTIVE: state_nx = ST_VFRONT;
                            ST_VFRONT: state_nx = enable ? ST_VSYNC : ST_IDLE;
                            default:   state_nx = ST_IDLE;
                        endcase
                    end else begin
                        v_nx = v + 1'b1;
                    end
                end else begin
                    h_nx = h + 1'b1;
                end
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next frame position
    // so that every output can be registered yet stay aligned with the counters.
    always_comb begin
        href_nx = (state_nx == ST_ACTIVE) && (h_nx < H_ACT_END);
        hi_slot = href_nx && !h_nx[0];
`ifdef DVP_TX_TEST_PATTERN_EN
        req_nx  = 1'b0;
`else
        req_nx  = ((state_nx == ST_ACTIVE) && !h_nx[0] && (h_nx < H_REQ_LIM)) ||
                  ((h_nx == H_REQ_FIRST) &&
                   (((state_nx == ST_VBACK) && (v_nx == VB_LAST)) ||
                    ((state_nx == ST_ACTIVE) && (v_nx != VA_LAST))));
`endif
        if (!href_nx) begin
            data_nx = 8'h00;
        end else if (hi_slot) begin
            data_nx = pixel[15:8];
        end else begin
            data_nx = low_byte;
        end
    end

    // Frame position, byte pipeline and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            h           <= '0;
            v           <= '0;
            low_byte    <= 8'h00;
            pix_req     <= 1'b0;
            dvp_vsync   <= 1'b0;
            dvp_href    <= 1'b0;
            dvp_data    <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            h           <= h_nx;
            v           <= v_nx;
            if (hi_slot) begin
                low_byte <= pixel[7:0];
            end
            pix_req     <= req_nx;
            dvp_vsync   <= (state_nx == ST_VSYNC);
            dvp_href    <= href_nx;
            dvp_data    <= data_nx;
            frame_start <= (state_nx == ST_VSYNC) && (h_nx == '0) && (v_nx == '0);
            frame_done  <= (state_nx == ST_VFRONT) && (h_nx == H_LAST) && (v_nx == VF_LAST);
            busy        <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_dvp_tx.sv
// tb_dvp_tx: self-checking bench for dvp_tx with small frame parameters.
// A frame-level reference model (cycle offset within the frame) predicts
// every output each cycle; the pixel source feeds counter or random pixels.
module tb_dvp_tx;

`ifdef DVP_TX_TEST_PATTERN_EN
    localparam int HA = 8;
`else
    localparam int HA = 4;
`endif
    localparam int VA = 2;
    localparam int HB = 3;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int LL = 2 * HA + HB;
    localparam int FL = (VS + VB + VA + VF) * LL;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        pix_req;
    logic [15:0] pix_data;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;
    logic        frame_start;
    logic        frame_done;
    logic        busy;

    int          tests    = 0;
    int          failures = 0;

    bit          m_busy   = 1'b0;
    int          m_t      = 0;
    logic [15:0] m_px     = 16'h0000;
    int          reqs     = 0;
    bit          src_rand = 1'b0;
    int          src_n    = 0;
    logic [15:0] srcq[$];
    logic [7:0]  line_bytes[$];

    dvp_tx #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_BLANK  (HB),
        .VSYNC_LEN(VS),
        .V_BACK   (VB),
        .V_FRONT  (VF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pix_req    (pix_req),
        .pix_data   (pix_data),
        .dvp_vsync  (dvp_vsync),
        .dvp_href   (dvp_href),
        .dvp_data   (dvp_data),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // Free-running byte clock.
    always #5 clk = ~clk;

    // Pixel source: answers each request with the next counter or random pixel.
    always @(negedge clk) begin
        if (pix_req === 1'b1) begin
            logic [15:0] px;
            px = src_rand ? 16'($urandom) : (16'hA000 + 16'(src_n));
            src_n = src_n + 1;
            srcq.push_back(px);
            pix_data = px;
        end
    end

    function automatic logic [15:0] patPix(int k);
        logic [15:0] cols[8];
        int bw, b;
        cols = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        bw = (HA / 8 < 1) ? 1 : HA / 8;
        b  = k / bw;
        if (b > 7) b = 7;
        return cols[b];
    endfunction

    task automatic checkVal(string tag, logic [15:0] obs, logic [15:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("[TB] FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    // Advance the frame model across one rising edge using pre-edge inputs.
    task automatic modelStep();
        if (rst) begin
            m_busy = 1'b0;
            m_t    = 0;
        end else if (!m_busy) begin
            if (enable) begin
                m_busy = 1'b1;
                m_t    = 0;
            end
        end else if (m_t == FL - 1) begin
            if (enable) m_t = 0;
            else m_busy = 1'b0;
        end else begin
            m_t = m_t + 1;
        end
    endtask

    // Compare every output against what the frame model predicts now.
    task automatic checkOutput();
        int ln, h, a, tt, l2, h2, a2;
        logic ex_vs, ex_href, ex_req, ex_fs, ex_fd;
        logic [7:0] ex_data;
        ln = m_t / LL;
        h  = m_t % LL;
        a  = ln - (VS + VB);
        ex_vs   = m_busy && (ln < VS);
        ex_href = m_busy && (a >= 0) && (a < VA) && (h < 2 * HA);
        ex_fs   = m_busy && (m_t == 0);
        ex_fd   = m_busy && (m_t == FL - 1);
        tt = m_t + 2;
        l2 = tt / LL;
        h2 = tt % LL;
        a2 = l2 - (VS + VB);
`ifdef DVP_TX_TEST_PATTERN_EN
        ex_req = 1'b0;
`else
        ex_req = m_busy && (a2 >= 0) && (a2 < VA) && (h2 < 2 * HA) && (h2 % 2 == 0);
`endif
        if (ex_href && (h % 2 == 0)) begin
`ifdef DVP_TX_TEST_PATTERN_EN
            m_px = patPix(h / 2);
`else
            checkVal("pixel_available", 16'(srcq.size() != 0), 16'd1);
            m_px = (srcq.size() != 0) ? srcq.pop_front() : 16'hxxxx;
`endif
        end
        ex_data = !ex_href ? 8'h00 : ((h % 2 == 0) ? m_px[15:8] : m_px[7:0]);
        checkVal("dvp_vsync",   16'(dvp_vsync),   16'(ex_vs));
        checkVal("dvp_href",    16'(dvp_href),    16'(ex_href));
        checkVal("dvp_data",    16'(dvp_data),    16'(ex_data));
        checkVal("pix_req",     16'(pix_req),     16'(ex_req));
        checkVal("frame_start", 16'(frame_start), 16'(ex_fs));
        checkVal("frame_done",  16'(frame_done),  16'(ex_fd));
        checkVal("busy",        16'(busy),        16'(m_busy));
        if (dvp_href === 1'b1) line_bytes.push_back(dvp_data);
        if (pix_req === 1'b1) reqs = reqs + 1;
    endtask

    task automatic applyStimulus(int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            checkOutput();
        end
    endtask

    // Compare the first bytes of the captured active line with a fixed list.
    task automatic checkLine();
`ifdef DVP_TX_TEST_PATTERN_EN
        logic [7:0] exp_line[16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                     8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
        localparam int N = 16;
`else
        logic [7:0] exp_line[8] = '{8'hA0, 8'h00, 8'hA0, 8'h01, 8'hA0, 8'h02, 8'hA0, 8'h03};
        localparam int N = 8;
`endif
        checkVal("line_len", 16'(line_bytes.size() >= N), 16'd1);
        for (int i = 0; i < N; i++) begin
            checkVal($sformatf("line_byte%0d", i),
                     16'((i < line_bytes.size()) ? line_bytes[i] : 8'hxx), 16'(exp_line[i]));
        end
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        pix_data = 16'h0000;
        applyStimulus(3);
        enable = 1'b1;
        applyStimulus(2);

        // Release reset with enable held: three back-to-back counter frames.
        rst = 1'b0;
        line_bytes.delete();
        reqs = 0;
        applyStimulus(3 * FL);
        checkLine();
        checkVal("reqs_3_frames", 16'(reqs), 16'(3 * HA * VA));

        // Random-pixel frame with enable dropped mid-ACTIVE.
        src_rand = 1'b1;
        reqs = 0;
        applyStimulus((VS + VB) * LL + 3);
        enable = 1'b0;
        applyStimulus(FL - ((VS + VB) * LL + 3) + 5);
        checkVal("reqs_last_frame", 16'(reqs), 16'(HA * VA));
        applyStimulus(10);

        // Start again, then hit reset while href is high.
        enable = 1'b1;
        applyStimulus((VS + VB) * LL + 3);
        checkVal("href_before_reset", 16'(dvp_href), 16'd1);
        #2 rst = 1'b1;
        #1;
        m_busy = 1'b0;
        m_t    = 0;
        srcq.delete();
        src_n    = 0;
        src_rand = 1'b0;
        checkOutput();
        line_bytes.delete();
        applyStimulus(2);
        rst = 1'b0;
        applyStimulus(2 * FL);
        checkLine();

        enable = 1'b0;
        applyStimulus(FL + 5);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
